// File: rtl/stage_seq_pkg.sv
// Shared types and constants for the stage sequencer.
package stage_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT,
      DONE,
      FAULT
   } state_e;

   localparam logic [2:0] LIGHT_IDLE  = 3'b100;
   localparam logic [2:0] LIGHT_FIRST = 3'b001;
   localparam logic [2:0] LIGHT_NEXT  = 3'b111;
   localparam logic [2:0] LIGHT_DONE  = 3'b101;
   localparam logic [2:0] LIGHT_FAULT = 3'b110;

   // Width of a stage index; never narrower than one bit.
   function automatic int unsigned idx_width(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Control/status bundle between the top-level control and the stage sequencer.
interface stage_sequencer_if
   import stage_seq_pkg::*;
#(
   parameter int unsigned N_STAGES = 2
);
   localparam int unsigned CW = idx_width(N_STAGES);

   logic                go;
   logic                abort;
   logic [N_STAGES-1:0] stage_done;
   logic [N_STAGES-1:0] stage_start;
   logic [CW-1:0]       cur_stage;
   logic                busy;
   logic                all_done;
   logic                fault;
   logic [2:0]          light;

   modport master (
      output go, abort, stage_done,
      input  stage_start, cur_stage, busy, all_done, fault, light
   );

   modport slave (
      input  go, abort, stage_done,
      output stage_start, cur_stage, busy, all_done, fault, light
   );

endinterface

// File: rtl/stage_watchdog.sv
// Per-stage watchdog: counts cycles while enabled and flags the cycle on which
// the count would reach LIMIT. Used by stage_sequencer under STAGE_TIMEOUT_EN.
module stage_watchdog #(
   parameter int unsigned LIMIT = 1000000
) (
   input  logic clok,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int unsigned W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LAST  = W'(LIMIT - 1);
   localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise count up while enabled, saturating.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != LIMIT_V)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clok) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // This enabled cycle is the LIMIT-th one since the last clear.
   assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Start/done sequencer launching N_STAGES stages in strict order.
// Optional per-stage watchdog enabled by defining STAGE_TIMEOUT_EN.
module stage_sequencer
   import stage_seq_pkg::*;
#(
   parameter int unsigned N_STAGES       = 2,
   parameter bit          AUTO_START     = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                clok,
   input  logic                rst,
   stage_sequencer_if.slave    bus
);
   localparam int unsigned CW = idx_width(N_STAGES);
   localparam logic [CW-1:0] LAST_IDX = CW'(N_STAGES - 1);

   state_e              state_q, state_d;
   logic [N_STAGES-1:0] start_q, start_d;
   logic [CW-1:0]       cur_q, cur_d;
   logic                busy_q, busy_d;
   logic                all_done_q, all_done_d;
   logic                fault_q, fault_d;
   logic [2:0]          light_q, light_d;
   logic                auto_q, auto_d;

   logic                done_cur;
   logic [CW-1:0]       cur_nxt;
   logic                wd_expired;

   assign done_cur = bus.stage_done[cur_q];
   assign cur_nxt  = cur_q + CW'(1);

`ifdef STAGE_TIMEOUT_EN
   logic wd_clear;
   logic wd_en;

   // Restart the count whenever a stage is issued (entry to WAIT or an advance).
   assign wd_clear = (state_d == WAIT) && ((state_q != WAIT) || (cur_d != cur_q));
   assign wd_en    = (state_q == WAIT);

   stage_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clok    (clok),
      .rst     (rst),
      .clear   (wd_clear),
      .enable  (wd_en),
      .expired (wd_expired)
   );
`else
   assign wd_expired = 1'b0;
`endif

   // Next-state and registered-output decisions.
   always_comb begin
      state_d    = state_q;
      start_d    = start_q;
      cur_d      = cur_q;
      busy_d     = busy_q;
      all_done_d = all_done_q;
      fault_d    = fault_q;
      light_d    = light_q;
      auto_d     = auto_q;
      unique case (state_q)
         IDLE: begin
            if (bus.go || auto_q) begin
               start_d[0] = 1'b1;
               busy_d     = 1'b1;
               light_d    = LIGHT_FIRST;
               auto_d     = 1'b0;
               state_d    = WAIT;
            end
         end
         ARM: begin
            start_d[0] = 1'b1;
            light_d    = LIGHT_FIRST;
            state_d    = WAIT;
         end
         WAIT: begin
            // abort beats done, done beats the watchdog
            if (bus.abort || (!done_cur && wd_expired)) begin
               start_d = '0;
               busy_d  = 1'b0;
               fault_d = 1'b1;
               light_d = LIGHT_FAULT;
               state_d = FAULT;
            end else if (done_cur) begin
               if (cur_q == LAST_IDX) begin
                  busy_d     = 1'b0;
                  all_done_d = 1'b1;
                  light_d    = LIGHT_DONE;
                  state_d    = DONE;
               end else begin
                  cur_d            = cur_nxt;
                  start_d[cur_nxt] = 1'b1;
                  light_d          = LIGHT_NEXT;
               end
            end
         end
         DONE, FAULT: begin
            // ARM keeps stage_start low for a cycle so each run sees a fresh edge
            if (bus.go) begin
               start_d    = '0;
               cur_d      = '0;
               all_done_d = 1'b0;
               fault_d    = 1'b0;
               busy_d     = 1'b1;
               light_d    = LIGHT_IDLE;
               state_d    = ARM;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clok) begin
      if (rst) begin
         state_q    <= IDLE;
         start_q    <= '0;
         cur_q      <= '0;
         busy_q     <= 1'b0;
         all_done_q <= 1'b0;
         fault_q    <= 1'b0;
         light_q    <= LIGHT_IDLE;
         auto_q     <= AUTO_START;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         cur_q      <= cur_d;
         busy_q     <= busy_d;
         all_done_q <= all_done_d;
         fault_q    <= fault_d;
         light_q    <= light_d;
         auto_q     <= auto_d;
      end
   end

   assign bus.stage_start = start_q;
   assign bus.cur_stage   = cur_q;
   assign bus.busy        = busy_q;
   assign bus.all_done    = all_done_q;
   assign bus.fault       = fault_q;
   assign bus.light       = light_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: a 2-stage auto-start instance and a 4-stage
// go-started instance, each tracked by a run-level model checked every cycle.
// The timeout scenario is built only when STAGE_TIMEOUT_EN is defined.
module tb_stage_sequencer;

   localparam int TMO = 8;
`ifdef STAGE_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clok = 1'b0;
   logic rst;
   always #5 clok = ~clok;

   stage_sequencer_if #(.N_STAGES(2)) bus2 ();
   stage_sequencer_if #(.N_STAGES(4)) bus4 ();

   stage_sequencer #(
      .N_STAGES       (2),
      .AUTO_START     (1'b1),
      .TIMEOUT_CYCLES (TMO)
   ) u_dut2 (
      .clok (clok),
      .rst  (rst),
      .bus  (bus2)
   );

   stage_sequencer #(
      .N_STAGES       (4),
      .AUTO_START     (1'b0),
      .TIMEOUT_CYCLES (TMO)
   ) u_dut4 (
      .clok (clok),
      .rst  (rst),
      .bus  (bus4)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Run-level view: how many stages have been issued, which one is awaited,
   // and the status flags; a pending re-arm models the one blank cycle.
   typedef struct {
      int         issued;
      int         cur;
      int         waitc;
      bit         busy;
      bit         alldone;
      bit         fault;
      bit         autof;
      bit         rearm;
      logic [2:0] light;
   } mdl_t;

   function automatic mdl_t step(input mdl_t m, input int n, input bit autop, input bit r,
                                 input bit g, input bit a, input logic [15:0] d);
      mdl_t s = m;
      if (r) begin
         s = '{issued: 0, cur: 0, waitc: 0, busy: 0, alldone: 0, fault: 0,
               autof: autop, rearm: 0, light: 3'b100};
      end else if (m.rearm) begin
         s.rearm  = 0;
         s.issued = 1;
         s.waitc  = 0;
         s.light  = 3'b001;
      end else if (m.busy) begin
         if (!a && d[m.cur]) begin
            if (m.cur < n - 1) begin
               s.cur++;
               s.issued++;
               s.waitc = 0;
               s.light = 3'b111;
            end else begin
               s.busy    = 0;
               s.alldone = 1;
               s.light   = 3'b101;
            end
         end else begin
            s.waitc++;
            if (a || (TMO_EN && s.waitc == TMO)) begin
               s.issued = 0;
               s.busy   = 0;
               s.fault  = 1;
               s.light  = 3'b110;
            end
         end
      end else if (m.alldone || m.fault) begin
         if (g) begin
            s.issued  = 0;
            s.cur     = 0;
            s.alldone = 0;
            s.fault   = 0;
            s.busy    = 1;
            s.rearm   = 1;
            s.light   = 3'b100;
         end
      end else if (g || m.autof) begin
         s.issued = 1;
         s.busy   = 1;
         s.autof  = 0;
         s.waitc  = 0;
         s.light  = 3'b001;
      end
      return s;
   endfunction

   mdl_t m2, m4;

   // Advance both models on each edge, then compare every output.
   always @(posedge clok) begin
      bit r, g2, a2, g4, a4;
      logic [15:0] d2, d4;
      r  = rst;
      g2 = bus2.go;
      a2 = bus2.abort;
      d2 = {14'b0, bus2.stage_done};
      g4 = bus4.go;
      a4 = bus4.abort;
      d4 = {12'b0, bus4.stage_done};
      m2 = step(m2, 2, 1'b1, r, g2, a2, d2);
      m4 = step(m4, 4, 1'b0, r, g4, a4, d4);
      #1;
      check("cyc2_start", 32'(bus2.stage_start), (32'd1 << m2.issued) - 32'd1);
      check("cyc2_cur",   32'(bus2.cur_stage),   32'(m2.cur));
      check("cyc2_busy",  32'(bus2.busy),        32'(m2.busy));
      check("cyc2_done",  32'(bus2.all_done),    32'(m2.alldone));
      check("cyc2_fault", 32'(bus2.fault),       32'(m2.fault));
      check("cyc2_light", 32'(bus2.light),       32'(m2.light));
      check("cyc4_start", 32'(bus4.stage_start), (32'd1 << m4.issued) - 32'd1);
      check("cyc4_cur",   32'(bus4.cur_stage),   32'(m4.cur));
      check("cyc4_busy",  32'(bus4.busy),        32'(m4.busy));
      check("cyc4_done",  32'(bus4.all_done),    32'(m4.alldone));
      check("cyc4_fault", 32'(bus4.fault),       32'(m4.fault));
      check("cyc4_light", 32'(bus4.light),       32'(m4.light));
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clok);
   endtask

   initial begin
      rst             = 1'b1;
      bus2.go         = 1'b0;
      bus2.abort      = 1'b0;
      bus2.stage_done = '0;
      bus4.go         = 1'b0;
      bus4.abort      = 1'b0;
      bus4.stage_done = '0;
      tick(2);
      check("rst2_start", 32'(bus2.stage_start), 32'h0);
      check("rst2_light", 32'(bus2.light), 32'h4);

      // Auto start: first stage issued after the first edge out of reset.
      rst = 1'b0;
      tick(1);
      check("auto2_start", 32'(bus2.stage_start), 32'h1);
      check("auto2_light", 32'(bus2.light), 32'h1);
      check("idle4_light", 32'(bus4.light), 32'h4);

      bus2.stage_done = 2'b01;
      tick(1);
      check("adv2_start", 32'(bus2.stage_start), 32'h3);
      check("adv2_light", 32'(bus2.light), 32'h7);
      bus2.stage_done = 2'b10;
      tick(1);
      check("fin2_done",  32'(bus2.all_done), 32'h1);
      check("fin2_light", 32'(bus2.light), 32'h5);
      check("fin2_start", 32'(bus2.stage_start), 32'h3);
      bus2.stage_done = 2'b00;

      // Restart from DONE: one blank cycle, then a fresh stage 0.
      bus2.go = 1'b1;
      tick(1);
      bus2.go = 1'b0;
      check("arm2_start", 32'(bus2.stage_start), 32'h0);
      check("arm2_light", 32'(bus2.light), 32'h4);
      tick(1);
      check("rerun2_start", 32'(bus2.stage_start), 32'h1);
      check("rerun2_light", 32'(bus2.light), 32'h1);

      // 4 stages: a done for a non-current stage is ignored.
      bus4.go = 1'b1;
      tick(1);
      bus4.go = 1'b0;
      check("go4_start", 32'(bus4.stage_start), 32'h1);
      bus4.stage_done = 4'b0100;
      tick(2);
      check("ign4_start", 32'(bus4.stage_start), 32'h1);
      check("ign4_cur",   32'(bus4.cur_stage), 32'h0);
      for (int k = 0; k < 3; k++) begin
         bus4.stage_done = 4'(1 << k);
         tick(1);
         check("step4_start", 32'(bus4.stage_start), (32'd1 << (k + 2)) - 32'd1);
      end
      bus4.stage_done = 4'b1000;
      tick(1);
      check("fin4_done", 32'(bus4.all_done), 32'h1);
      bus4.stage_done = 4'b0000;

      // Abort together with the current stage's done: abort wins.
      bus4.go = 1'b1;
      tick(1);
      bus4.go = 1'b0;
      tick(1);
      bus4.stage_done = 4'b0001;
      tick(1);
      bus4.stage_done = 4'b0010;
      bus4.abort      = 1'b1;
      tick(1);
      bus4.stage_done = 4'b0000;
      bus4.abort      = 1'b0;
      check("abort4_fault", 32'(bus4.fault), 32'h1);
      check("abort4_start", 32'(bus4.stage_start), 32'h0);
      check("abort4_cur",   32'(bus4.cur_stage), 32'h1);
      check("abort4_light", 32'(bus4.light), 32'h6);

      // Restart from FAULT, advance to stage 2, then reset mid-run.
      bus4.go = 1'b1;
      tick(1);
      bus4.go = 1'b0;
      tick(1);
      check("rerun4_start", 32'(bus4.stage_start), 32'h1);
      bus4.stage_done = 4'b0001;
      tick(1);
      bus4.stage_done = 4'b0010;
      tick(1);
      bus4.stage_done = 4'b0000;
      check("mid4_cur", 32'(bus4.cur_stage), 32'h2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("mrst4_start", 32'(bus4.stage_start), 32'h0);
      check("mrst4_cur",   32'(bus4.cur_stage), 32'h0);
      check("mrst4_busy",  32'(bus4.busy), 32'h0);
      check("mrst4_fault", 32'(bus4.fault), 32'h0);
      check("mrst4_light", 32'(bus4.light), 32'h4);

`ifdef STAGE_TIMEOUT_EN
      // No done: fault on the 8th WAIT cycle, not before.
      bus4.go = 1'b1;
      tick(1);
      bus4.go = 1'b0;
      tick(TMO - 1);
      check("tmo4_early", 32'(bus4.fault), 32'h0);
      tick(1);
      check("tmo4_fault", 32'(bus4.fault), 32'h1);
      check("tmo4_light", 32'(bus4.light), 32'h6);
      // Done arriving on the 8th WAIT cycle advances instead.
      bus4.go = 1'b1;
      tick(1);
      bus4.go = 1'b0;
      tick(1);
      tick(TMO - 1);
      bus4.stage_done = 4'b0001;
      tick(1);
      bus4.stage_done = 4'b0000;
      check("tmo4_win_fault", 32'(bus4.fault), 32'h0);
      check("tmo4_win_start", 32'(bus4.stage_start), 32'h3);
`else
      // Without the watchdog a stage waits indefinitely.
      bus4.go = 1'b1;
      tick(1);
      bus4.go = 1'b0;
      tick(40);
      check("wait4_fault", 32'(bus4.fault), 32'h0);
      check("wait4_busy",  32'(bus4.busy), 32'h1);
`endif

      tick(2);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised start/done sequencer that launches N processing stages in strict order, holding each stage's start level high once issued, and advancing only on that stage's done. It sits between the top-level control and the loop/processing engines of the lab datapath and drives the 3-bit status lights. Adds over the two-loop handler: configurable stage count, restart via `go`, abort, fault reporting, and an optional per-stage watchdog.

## Interface
- `N_STAGES`, 2: number of sequenced stages; legal range 1..16.
- `AUTO_START`, 1: 1 means the first run starts immediately after reset without `go`; 0 means wait for `go`.
- `TIMEOUT_CYCLES`, 1000000: per-stage watchdog limit; used only with `STAGE_TIMEOUT_EN`.
- `clok`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `go`  in  1  restart request, sampled in IDLE/DONE/FAULT; ignored in ARM/WAIT.
- `abort`  in  1  abort the current run; honoured only in WAIT.
- `stage_done`  in  N_STAGES  per-stage done level; only bit `cur_stage` is examined.
- `stage_start`  out  N_STAGES  cumulative start levels; bit k stays high once issued.
- `cur_stage`  out  max(1,$clog2(N_STAGES))  index of the stage being awaited; holds the faulting stage in FAULT.
- `busy`  out  1  high in ARM/WAIT.
- `all_done`  out  1  high in DONE.
- `fault`  out  1  high in FAULT.
- `light`  out  3  status lights.

## Operation
- Reset values: `stage_start`=0, `cur_stage`=0, `busy`=0, `all_done`=0, `fault`=0, `light`=3'b100, state IDLE, auto flag=`AUTO_START`.
- Reset mid-run aborts everything; no output state survives.
- IDLE: if `go`=1 or the auto flag is set, then set `stage_start[0]`=1, `busy`=1, `light`=001, clear the auto flag, and go to WAIT. Otherwise stay.
- WAIT, evaluated in priority order:
  - `abort`=1: `stage_start`=0, `busy`=0, `fault`=1, `light`=110, go to FAULT; `cur_stage` holds.
  - `stage_done[cur_stage]`=1 and `cur_stage`<N_STAGES-1: increment `cur_stage`, set the next `stage_start` bit, `light`=111, stay in WAIT.
  - `stage_done[cur_stage]`=1 and `cur_stage`=N_STAGES-1: `busy`=0, `all_done`=1, `light`=101, go to DONE; `stage_start` stays all-ones.
  - `stage_done` bits for other stages are ignored.
- DONE / FAULT: hold all outputs. On `go`, go to ARM: clear `stage_start`, `cur_stage`, `all_done`, `fault`; set `busy`=1, `light`=100.
- ARM: unconditionally set `stage_start[0]`=1, `light`=001, go to WAIT. This guarantees `stage_start` is low for at least one cycle between runs, so every run begins with a fresh rising edge.
- N_STAGES=1: the first done goes straight to DONE.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- With AUTO_START=1, `stage_start[0]` is high after the 1st rising edge with `rst`=0.
- `go` sampled at edge n in IDLE: `stage_start[0]` is high after edge n.
- `go` sampled at edge n in DONE/FAULT: `stage_start` is 0 after edge n and `stage_start[0]` is high after edge n+1.
- `stage_done[k]` sampled at edge n: `stage_start[k+1]` (or `all_done`) is high after edge n. Latency is 1 cycle.
- The done level is not consumed. A done that is already high when its stage is started advances on the next edge, so each stage advances at most one step per cycle.

## Configuration
- `STAGE_TIMEOUT_EN` defined:
  - A watchdog counter clears to 0 on every stage issue (IDLE/ARM exit and each WAIT advance).
  - It increments every cycle in WAIT.
  - When it reaches `TIMEOUT_CYCLES` without done, the block takes the abort path (`fault`=1, `light`=110).
  - Priority: `abort` > `stage_done` > timeout. A done on the limit cycle wins.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- `STAGE_TIMEOUT_EN` undefined: no counter; WAIT waits indefinitely and faults only on `abort`. `TIMEOUT_CYCLES` is unused.

## Structure
- Package `stage_seq_pkg` holds:
  - state enum IDLE/ARM/WAIT/DONE/FAULT;
  - light constants `LIGHT_IDLE`=100, `LIGHT_FIRST`=001, `LIGHT_NEXT`=111, `LIGHT_DONE`=101, `LIGHT_FAULT`=110.
- Sub-module `stage_watchdog` (clear, enable, expired; parameter LIMIT), instantiated only under `STAGE_TIMEOUT_EN`.

## Test plan
- N=2, AUTO_START=1: release `rst`; `stage_start`=01 after edge 1; pulse `stage_done[0]` → `stage_start`=11, `light`=111; pulse `stage_done[1]` → `all_done`=1, `light`=101.
- N=4: raise `stage_done[2]` while `cur_stage`=0 → no advance; then step 0..3 → `stage_start` goes 0001→0011→0111→1111.
- `abort` together with `stage_done[1]` while `cur_stage`=1 → `fault`=1, `stage_start`=0, `cur_stage`=1, `light`=110.
- In DONE, pulse `go` → one cycle with `stage_start`=0 and `light`=100, then `stage_start[0]`=1, `light`=001.
- `STAGE_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8: no done → fault after 8 WAIT cycles. Done on the 8th cycle → advance, no fault.
- Assert `rst` mid-run with `cur_stage`=2 → all outputs return to reset values on the next edge.
